// File: rtl/md_unit_if.sv
// md_unit_if: request (start/op/operands) and status (busy/HI/LO) bundle for md_unit
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output start, op, src_a, src_b, input busy, hi, lo);
  modport slave(input start, op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div unit owning HI/LO; define MD_UNIT_MADD_EN to enable madd/maddu
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  md
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [63:0]    pend, prod, res, res_div;
  logic [31:0]    hi_r, lo_r, uq, ur;
  logic signed [31:0] sq, sr;
  logic signed [63:0] sprod;
  logic           acc, acc_en, is_mul, is_div, go, done;
`ifdef MD_UNIT_MADD_EN
  assign is_mul = md.op inside {3'd0, 3'd1, 3'd6, 3'd7};
  assign acc_en = md.op[2];
`else
  assign is_mul = md.op inside {3'd0, 3'd1};
  assign acc_en = 1'b0;
`endif
  assign is_div  = md.op inside {3'd2, 3'd3};
  assign sprod   = 64'($signed(md.src_a)) * 64'($signed(md.src_b));
  assign prod    = md.op[0] ? {32'd0, md.src_a} * {32'd0, md.src_b} : sprod;
  assign sq      = $signed(md.src_a) / $signed(md.src_b);
  assign sr      = $signed(md.src_a) % $signed(md.src_b);
  assign uq      = md.src_a / md.src_b;
  assign ur      = md.src_a % md.src_b;
  assign res_div = md.src_b == 32'd0 ? {md.src_a, 32'hFFFF_FFFF} :
                   md.op[0] ? {ur, uq} :
                   (md.src_a == 32'h8000_0000 && md.src_b == 32'hFFFF_FFFF) ? {32'd0, 32'h8000_0000} :
                   {sr, sq};
  assign res     = is_div ? res_div : prod;
  // accept a multi-cycle op from IDLE; leave RUN on the commit edge
  always_comb begin
    go      = state == IDLE && md.start && (is_mul || is_div);
    done    = state == RUN && cnt == CW'(1);
    state_n = go ? RUN : done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // operand capture, countdown, HI/LO commit and mthi/mtlo writes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt  <= '0;
      pend <= '0;
      acc  <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (go) begin
        pend <= res;
        acc  <= acc_en;
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == RUN) cnt <= cnt - CW'(1);
      if (done) {hi_r, lo_r} <= acc ? {hi_r, lo_r} + pend : pend;
      else if (state == IDLE && md.start && md.op == 3'd4) hi_r <= md.src_a;
      else if (state == IDLE && md.start && md.op == 3'd5) lo_r <= md.src_a;
    end
  assign md.busy = state == RUN;
  assign md.hi   = hi_r;
  assign md.lo   = lo_r;
endmodule

// File: doc/md_unit.md
# md_unit

- Multi-cycle multiply/divide unit owning the HI/LO registers for the CPU datapath.
- Takes its operands from the register file read ports and runs mult/multu/div/divu over a fixed number of cycles, with a start/busy handshake.
- Exposes HI and LO to the writeback path for mfhi/mflo; the control unit stalls issue of HI/LO-dependent instructions while `busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy duration of multiply ops, ≥1.
- `DIV_CYCLES`, default 10: busy duration of divide ops, ≥1.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `start`  in  1: operation request, sampled on the rising edge.
- `op`  in  3: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- `src_a`  in  32: rs operand.
- `src_b`  in  32: rt operand.
- `busy`  out  1: an operation is in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- Reset state: `busy`=0, `hi`=0, `lo`=0, internal counter 0, pending result 0. Reset asserted mid-operation aborts the operation; the pending result is discarded.
- States: IDLE and RUN.
- IDLE, `start`=1, op 0-3 or 6-7 (enabled):
  - Compute the 64-bit result from `src_a`/`src_b` sampled this edge.
  - Store it in a pending register.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`, set `busy`=1, go to RUN.
- IDLE, `start`=1, op 4/5: write `src_a` into HI/LO at this edge; `busy` stays 0; stay in IDLE.
- RUN, each edge: decrement the counter. At the edge where the counter is 1:
  - Commit pending to {hi,lo}.
  - Clear `busy`, return to IDLE.
- `start` while `busy`=1 is ignored entirely, including mthi/mtlo. Preventing this is the control unit's job.
- Arithmetic:
  - mult: {hi,lo} = signed 32×32 → 64.
  - multu: {hi,lo} = unsigned 32×32 → 64.
  - div/divu: lo = quotient, hi = remainder (signed/unsigned).
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero (src_b=0): lo=32'hFFFF_FFFF, hi=src_a, for both div and divu.
  - Signed overflow (0x8000_0000 / 0xFFFF_FFFF): lo=0x8000_0000, hi=0.
- `hi`/`lo` keep their old values throughout RUN. Only the commit edge changes them.

## Timing
- Start accepted at edge k (IDLE, `start`=1): `busy` is high from after edge k through edge k+N, where N is the cycle count.
- Commit at edge k+N: `hi`/`lo` show the new values after edge k+N, and `busy` is low in the same cycle.
- A new `start` is accepted at edge k+N+1 at the earliest. There is no back-to-back overlap at the commit edge.
- mthi/mtlo: the value is visible after the accepting edge. Zero stall.
- `busy`, `hi`, `lo` are registered outputs with no combinational path from inputs.

## Configuration
- Macro `MD_UNIT_MADD_EN`.
- Defined:
  - op 6 madd: {hi,lo} += signed(src_a×src_b).
  - op 7 maddu: {hi,lo} += unsigned product.
  - Accumulation is modulo 2^64, using the {hi,lo} value at commit, with `MULT_CYCLES` latency.
- Undefined: op 6/7 is a no-op. `busy` stays 0 and HI/LO are unchanged.

## Test plan
- **Reset:** reset pulsed asynchronously mid-cycle → `busy`=0, `hi`=`lo`=0 immediately, without waiting for a clock edge.
- **Signed mult:** mult with src_a=0xFFFF_FFFE (-2), src_b=3 →
  - `busy` high exactly 5 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
  - multu with the same operands → hi=0x0000_0002, lo=0xFFFF_FFFA.
- **Signed div:** div with src_a=-7 (0xFFFF_FFF9), src_b=2 →
  - After 10 busy cycles: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - divu with src_a=7, src_b=0 → lo=0xFFFF_FFFF, hi=7.
- **Signed overflow:** div with src_a=0x8000_0000, src_b=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- **Busy and abort:**
  - During RUN, `start` with op=mthi, src_a=0x1234 → ignored; hi still holds the pre-op value until commit.
  - mthi in IDLE → hi=0x1234 after one edge, `busy` never rises.
  - Reset at busy cycle 3 → no commit occurs.
- **Accumulate (`MD_UNIT_MADD_EN` defined):** hi=0, lo=0xFFFF_FFFF, then maddu with src_a=1, src_b=1 → hi=1, lo=0.
  - Without the macro, the same stimulus leaves hi/lo unchanged and `busy`=0.
